sat_timer_bank: RTL and testbench

Bank of CHANNELS independent saturating timers sharing one clock and one tick strobe. Each channel is configured for one of four modes: idle, one-shot countdown, auto-reload countdown, or saturating up-count with a programmable ceiling. Each channel reports its count, a sticky done flag and a one-cycle expire pulse. It sits between the tick prescaler and the traffic-light phase FSM, and replaces per-phase single countdown timers with one configurable bank.

---
 rtl/sat_timer_bank.sv | 117 +++++++++++
 tb/tb_sat_timer_bank.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_timer_bank.sv
// rtl/sat_timer_bank.sv - bank of independent saturating timer channels
// Each channel: idle, one-shot down, auto-reload down or saturating up-count.
module sat_timer_bank #(
  parameter int COUNT_SIZE = 7,
  parameter int CHANNELS   = 4,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           tick,
  input  logic                           wr_en,
  input  logic [CH_W-1:0]                ch_sel,
  input  logic [COUNT_SIZE-1:0]          wr_val,
  input  logic [COUNT_SIZE-1:0]          wr_max,
  input  logic [1:0]                     wr_mode,
  input  logic [CHANNELS-1:0]            start,
  input  logic [CHANNELS-1:0]            stop,
  output logic [CHANNELS*COUNT_SIZE-1:0] count,
  output logic [CHANNELS-1:0]            busy,
  output logic [CHANNELS-1:0]            done,
  output logic [CHANNELS-1:0]            expire
);

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_ONE  = 2'b01;
  localparam logic [1:0] MODE_AUTO = 2'b10;
  localparam logic [1:0] MODE_UP   = 2'b11;

  localparam logic [COUNT_SIZE-1:0] ONE  = COUNT_SIZE'(1);
  localparam logic [COUNT_SIZE-1:0] ZERO = '0;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [COUNT_SIZE-1:0] cnt_q;
    logic [COUNT_SIZE-1:0] rld_q;
    logic [COUNT_SIZE-1:0] max_q;
    logic [1:0]            mode_q;
    logic                  run_q;
    logic                  done_q;
    logic                  exp_q;
    logic                  sel;

    assign sel = wr_en && (ch_sel == CH_W'(i));

    // Priority chain: clr, write, stop, start, then tick on an already-running channel.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q  <= ZERO;
        rld_q  <= ZERO;
        max_q  <= ZERO;
        mode_q <= MODE_IDLE;
        run_q  <= 1'b0;
        done_q <= 1'b0;
        exp_q  <= 1'b0;
      end else begin
        exp_q <= 1'b0;
        if (clr) begin
          cnt_q  <= ZERO;
          run_q  <= 1'b0;
          done_q <= 1'b0;
        end else if (sel) begin
          rld_q  <= wr_val;
          max_q  <= wr_max;
          mode_q <= wr_mode;
          run_q  <= 1'b0;
          done_q <= 1'b0;
          cnt_q  <= (wr_mode == MODE_UP && wr_val > wr_max) ? wr_max : wr_val;
        end else if (stop[i]) begin
          run_q <= 1'b0;
        end else if (start[i]) begin
          if (mode_q != MODE_IDLE) begin
            run_q  <= 1'b1;
            done_q <= 1'b0;
          end
        end else if (tick && run_q) begin
          case (mode_q)
            MODE_ONE: begin
              if (cnt_q > ONE) begin
                cnt_q <= cnt_q - ONE;
              end else begin
                cnt_q  <= ZERO;
                run_q  <= 1'b0;
                done_q <= 1'b1;
                exp_q  <= 1'b1;
              end
            end
            MODE_AUTO: begin
              if (cnt_q > ONE) begin
                cnt_q <= cnt_q - ONE;
              end else begin
                cnt_q <= rld_q;
                exp_q <= 1'b1;
              end
            end
            MODE_UP: begin
              // cnt_q < max_q guarantees the increment cannot wrap
              if (cnt_q < max_q) begin
                cnt_q <= cnt_q + ONE;
                if (cnt_q + ONE == max_q) begin
                  done_q <= 1'b1;
                  exp_q  <= 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign count[i*COUNT_SIZE +: COUNT_SIZE] = cnt_q;
    assign busy[i]   = run_q;
    assign done[i]   = done_q;
    assign expire[i] = exp_q;
  end

endmodule

// File: tb/tb_sat_timer_bank.sv
// tb/tb_sat_timer_bank.sv - self-checking bench for sat_timer_bank
// Directed scenarios followed by randomized traffic against an integer reference model.
module tb_sat_timer_bank;

  localparam int CS  = 7;
  localparam int CH  = 4;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic              tick;
  logic              wr_en;
  logic [CHW-1:0]    ch_sel;
  logic [CS-1:0]     wr_val;
  logic [CS-1:0]     wr_max;
  logic [1:0]        wr_mode;
  logic [CH-1:0]     start;
  logic [CH-1:0]     stop;
  logic [CH*CS-1:0]  count;
  logic [CH-1:0]     busy;
  logic [CH-1:0]     done;
  logic [CH-1:0]     expire;

  int tests = 0;
  int fails = 0;

  int m_cnt [CH];
  int m_rld [CH];
  int m_max [CH];
  int m_mode[CH];
  bit m_run [CH];
  bit m_done[CH];
  bit m_exp [CH];

  sat_timer_bank #(.COUNT_SIZE(CS), .CHANNELS(CH), .CH_W(CHW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .tick(tick), .wr_en(wr_en), .ch_sel(ch_sel),
    .wr_val(wr_val), .wr_max(wr_max), .wr_mode(wr_mode), .start(start), .stop(stop),
    .count(count), .busy(busy), .done(done), .expire(expire)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_rld[c] = 0; m_max[c] = 0; m_mode[c] = 0;
      m_run[c] = 0; m_done[c] = 0; m_exp[c] = 0;
    end
  endtask

  task automatic model_tick(input int c);
    case (m_mode[c])
      1: begin
        m_cnt[c] = (m_cnt[c] > 0) ? m_cnt[c] - 1 : 0;
        if (m_cnt[c] == 0) begin
          m_run[c] = 0; m_done[c] = 1; m_exp[c] = 1;
        end
      end
      2: begin
        if (m_cnt[c] <= 1) begin
          m_cnt[c] = m_rld[c]; m_exp[c] = 1;
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end
      3: begin
        if (m_cnt[c] < m_max[c]) begin
          m_cnt[c] = m_cnt[c] + 1;
          if (m_cnt[c] == m_max[c]) begin
            m_done[c] = 1; m_exp[c] = 1;
          end
        end
      end
      default: ;
    endcase
  endtask

  // Next state for the inputs currently presented, applied at the coming edge.
  task automatic model_edge();
    if (!rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < CH; c++) begin
      m_exp[c] = 0;
      if (clr) begin
        m_cnt[c] = 0; m_run[c] = 0; m_done[c] = 0;
      end else if (wr_en && int'(ch_sel) == c) begin
        m_rld[c]  = int'(wr_val);
        m_max[c]  = int'(wr_max);
        m_mode[c] = int'(wr_mode);
        m_run[c]  = 0;
        m_done[c] = 0;
        m_cnt[c]  = (wr_mode == 2'b11 && wr_val > wr_max) ? int'(wr_max) : int'(wr_val);
      end else if (stop[c]) begin
        m_run[c] = 0;
      end else if (start[c]) begin
        if (m_mode[c] != 0) begin
          m_run[c] = 1; m_done[c] = 0;
        end
      end else if (tick && m_run[c]) begin
        model_tick(c);
      end
    end
  endtask

  task automatic check(input string tag);
    logic [CH*CS-1:0] e_count;
    logic [CH-1:0]    e_busy, e_done, e_exp;
    for (int c = 0; c < CH; c++) begin
      e_count[c*CS +: CS] = CS'(m_cnt[c]);
      e_busy[c] = m_run[c];
      e_done[c] = m_done[c];
      e_exp[c]  = m_exp[c];
    end
    tests++;
    assert (count === e_count) else begin
      fails++; $error("FAIL %s count got %h exp %h", tag, count, e_count);
    end
    tests++;
    assert (busy === e_busy) else begin
      fails++; $error("FAIL %s busy got %b exp %b", tag, busy, e_busy);
    end
    tests++;
    assert (done === e_done) else begin
      fails++; $error("FAIL %s done got %b exp %b", tag, done, e_done);
    end
    tests++;
    assert (expire === e_exp) else begin
      fails++; $error("FAIL %s expire got %b exp %b", tag, expire, e_exp);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++; $error("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_cnt(input int c);
    return int'(count[c*CS +: CS]);
  endfunction

  task automatic clear_inputs();
    clr = 0; tick = 0; wr_en = 0; ch_sel = '0; wr_val = '0; wr_max = '0;
    wr_mode = 2'b00; start = '0; stop = '0;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check(tag);
    clr = 0; tick = 0; wr_en = 0; start = '0; stop = '0;
  endtask

  task automatic wr(input int c, input int mode, input int val, input int mx);
    wr_en = 1; ch_sel = CHW'(c); wr_mode = 2'(mode); wr_val = CS'(val); wr_max = CS'(mx);
    step("write");
  endtask

  task automatic randomize_inputs();
    clr     = ($urandom_range(0, 49) == 0);
    tick    = 1'($urandom_range(0, 1));
    wr_en   = ($urandom_range(0, 9) == 0);
    ch_sel  = CHW'($urandom);
    wr_mode = 2'($urandom);
    wr_val  = ($urandom_range(0, 7) == 0) ? CS'($urandom) : CS'($urandom_range(0, 8));
    wr_max  = ($urandom_range(0, 7) == 0) ? CS'($urandom) : CS'($urandom_range(0, 8));
    start   = CH'($urandom & $urandom);
    stop    = CH'($urandom & $urandom & $urandom & $urandom);
  endtask

  initial begin
    model_reset();
    clear_inputs();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      randomize_inputs();
      step("reset_hold");
    end
    clear_inputs();
    #2 rst = 1;
    step("reset_release");
    for (int c = 0; c < CH; c++) chk("reset_count", get_cnt(c), 0);

    // one-shot on ch0
    wr(0, 1, 3, 0);
    chk("os_write_count", get_cnt(0), 3);
    start[0] = 1; step("os_start");
    for (int k = 0; k < 3; k++) begin
      tick = 1; step("os_tick");
      chk("os_count", get_cnt(0), 2 - k);
      chk("os_expire", expire[0], (k == 2) ? 1 : 0);
    end
    chk("os_done", done[0], 1);
    chk("os_busy", busy[0], 0);
    tick = 1; step("os_tick4");
    chk("os_tick4_count", get_cnt(0), 0);
    chk("os_tick4_expire", expire[0], 0);
    chk("os_tick4_done", done[0], 1);

    // auto-reload on ch1
    wr(1, 2, 4, 0);
    start[1] = 1; step("ar_start");
    for (int k = 1; k <= 12; k++) begin
      tick = 1; step("ar_tick");
      chk("ar_expire", expire[1], (k % 4 == 0) ? 1 : 0);
      chk("ar_count", get_cnt(1), (k % 4 == 0) ? 4 : 4 - (k % 4));
      chk("ar_busy", busy[1], 1);
    end
    wr(1, 2, 0, 0);
    start[1] = 1; step("ar0_start");
    for (int k = 0; k < 3; k++) begin
      tick = 1; step("ar0_tick");
      chk("ar0_expire", expire[1], 1);
    end

    // up saturating on ch2
    wr(2, 3, 9, 5);
    chk("up_clamp", get_cnt(2), 5);
    start[2] = 1; step("up_start");
    for (int k = 0; k < 3; k++) begin
      tick = 1; step("up_sat_tick");
      chk("up_sat_expire", expire[2], 0);
    end
    wr(2, 3, 3, 5);
    start[2] = 1; step("up_restart");
    for (int k = 0; k < 4; k++) begin
      tick = 1; step("up_tick");
      chk("up_count", get_cnt(2), (k == 0) ? 4 : 5);
      chk("up_expire", expire[2], (k == 1) ? 1 : 0);
    end
    chk("up_done", done[2], 1);

    // priority on ch3
    wr(3, 2, 5, 0);
    start[3] = 1; stop[3] = 1; step("pri_start_stop");
    chk("pri_start_stop_busy", busy[3], 0);
    wr_en = 1; ch_sel = 2'd3; wr_mode = 2'b10; wr_val = 7'd5; start[3] = 1;
    step("pri_write_start");
    chk("pri_write_start_busy", busy[3], 0);
    start[3] = 1; step("pri_start");
    tick = 1; step("pri_tick");
    chk("pri_tick_count", get_cnt(3), 4);
    start[3] = 1; tick = 1; step("pri_start_tick");
    chk("pri_start_tick_count", get_cnt(3), 4);
    tick = 1; step("pri_tick2");
    clr = 1; step("pri_clr");
    chk("pri_clr_count", get_cnt(3), 0);
    chk("pri_clr_busy", busy[3], 0);
    start[3] = 1; step("pri_restart");
    tick = 1; step("pri_reload");
    chk("pri_reload_count", get_cnt(3), 5);
    chk("pri_reload_expire", expire[3], 1);

    // asynchronous reset between edges while running
    wr(0, 1, 20, 0);
    start = 4'b1111; step("async_start");
    tick = 1; step("async_tick");
    #2 rst = 0;
    #1;
    model_reset();
    check("async_rst_mid");
    step("async_hold");
    #2 rst = 1;
    for (int k = 0; k < 3; k++) begin
      tick = 1; start = 4'b1111; step("async_after");
      chk("async_no_expire", int'(expire), 0);
    end

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      randomize_inputs();
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
